// File: rtl/ahb_code_mem_slave.sv
// AHB-Lite read-only instruction memory slave with configurable wait states,
// a two-cycle ERROR response for illegal accesses and a side-band load port.
module ahb_code_mem_slave #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [2:0]    HBURST,
  input  logic [3:0]    HPROT,
  input  logic          HMASTLOCK,
  input  logic          HREADY,
  output logic [31:0]   HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_wdata
);

  // state | meaning
  // IDLE  | no data phase in progress, ready
  // WAIT  | legal read accepted, counting wait states
  // DATA  | read data presented, OKAY
  // ERR1  | first ERROR cycle, HREADYOUT low
  // ERR2  | second ERROR cycle, HREADYOUT high
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd4;

  logic [31:0]   mem [DEPTH];
  state_t        state;
  logic [3:0]    cnt;
  logic [31:0]   rd_buf;

  logic          accept;
  logic          in_range;
  logic          addr_err;
  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          unused_bits;

  assign accept   = HSEL && HREADY && HTRANS[1];
  assign in_range = (HADDR >= BASE_ADDR) && ({1'b0, HADDR} < END_ADDR);
  assign addr_err = HWRITE || (HSIZE != 3'b010) || (HADDR[1:0] != 2'b00) || !in_range;
  // Subtract only once the address is known to be inside the window.
  assign offset   = in_range ? (HADDR - BASE_ADDR) : 32'd0;
  assign idx      = offset[AW+1:2];

  assign unused_bits = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], offset[31:AW+2], offset[1:0]};

  always_ff @(posedge CLK) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_wdata;
    end
  end

  // Memory is sampled on the accept edge, so a same-edge load is seen by the next read only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'd0;
      cnt       <= 4'd0;
      rd_buf    <= 32'd0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_DATA;
            HREADYOUT <= 1'b1;
            HRDATA    <= rd_buf;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          HREADYOUT <= 1'b1;
        end
        default: begin
          if (accept) begin
            if (addr_err) begin
              state     <= S_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
              HRDATA    <= 32'd0;
            end else if (WAIT_STATES == 0) begin
              state     <= S_DATA;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              HRDATA    <= mem[idx];
            end else begin
              state     <= S_WAIT;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
              cnt       <= 4'(WAIT_STATES - 1);
              rd_buf    <= mem[idx];
            end
          end else begin
            state     <= S_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_code_mem_slave.sv
// Scoreboard bench for ahb_code_mem_slave: three instances with different wait
// states share one bus and one memory image; a monitor checks every data phase.
`timescale 1ns/1ps
module tb_ahb_code_mem_slave;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int N     = 3;
  localparam logic [11:0] WS_PACK = {4'd2, 4'd3, 4'd0};

  logic          clk = 1'b0;
  logic          rst;
  logic          hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [3:0]    hprot;
  logic          hmastlock;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  int            cur;

  logic          hsel_v    [N];
  logic [31:0]   hrdata    [N];
  logic          hreadyout [N];
  logic          hresp     [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign hsel_v[g] = hsel && (cur == g);
    ahb_code_mem_slave #(
      .DEPTH(DEPTH),
      .BASE_ADDR(32'h0000_0000),
      .WAIT_STATES(int'(WS_PACK[g*4 +: 4]))
    ) u_dut (
      .CLK(clk), .RST(rst), .HSEL(hsel_v[g]), .HADDR(haddr), .HTRANS(htrans),
      .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
      .HMASTLOCK(hmastlock), .HREADY(hreadyout[g]), .HRDATA(hrdata[g]),
      .HREADYOUT(hreadyout[g]), .HRESP(hresp[g]),
      .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata)
    );
  end

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic        resp;
    int          waits;
  } exp_t;

  exp_t        exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] hold_exp  [N];

  function automatic int ws_of(input int i);
    return int'(WS_PACK[i*4 +: 4]);
  endfunction

  function automatic logic is_err(input logic [31:0] a, input logic w, input logic [2:0] sz);
    return w || (sz != 3'b010) || (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: a data phase starts on each accepting edge and ends when HREADYOUT is high.
  bit   phase   [N];
  bit   saw_err [N];
  int   waits_m [N];
  exp_t e_mon;

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) phase[i] = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (phase[i] && hreadyout[i]) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_response dut%0d: actual response with no transfer, required none", i);
          end else begin
            e_mon = exp_q.pop_front();
            check($sformatf("dut%0d_id", i), 32'(i), 32'(e_mon.dut));
            check($sformatf("dut%0d_hresp", i), {31'd0, hresp[i]}, {31'd0, e_mon.resp});
            check($sformatf("dut%0d_wait_cycles", i), 32'(waits_m[i]), 32'(e_mon.waits));
            check($sformatf("dut%0d_err_first_cycle", i), {31'd0, saw_err[i]}, {31'd0, e_mon.resp});
            check($sformatf("dut%0d_hrdata", i), hrdata[i], e_mon.resp ? 32'd0 : e_mon.data);
            hold_exp[i] = e_mon.resp ? 32'd0 : e_mon.data;
          end
          phase[i] = 1'b0;
        end else if (phase[i]) begin
          waits_m[i]++;
          if (hresp[i]) saw_err[i] = 1'b1;
        end
        if (hsel_v[i] && hreadyout[i] && htrans[1]) begin
          phase[i]   = 1'b1;
          waits_m[i] = 0;
          saw_err[i] = 1'b0;
        end
      end
    end
  end

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_wdata = d;
    model_mem[a] = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic xfer(input logic [31:0] a, input logic [1:0] tr, input logic s,
                      input logic w, input logic [2:0] sz,
                      input logic do_ld, input logic [AW-1:0] la, input logic [31:0] ld_d);
    int   guard;
    exp_t e;
    hsel = s; haddr = a; htrans = tr; hwrite = w; hsize = sz;
    hburst = 3'($urandom); hprot = 4'($urandom); hmastlock = 1'($urandom);
    @(negedge clk);
    guard = 0;
    while (!hreadyout[cur] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout dut%0d: actual HREADYOUT low 40 cycles, required high", cur);
    end
    if (s && tr[1]) begin
      e.dut   = cur;
      e.resp  = is_err(a, w, sz);
      e.waits = e.resp ? 1 : ws_of(cur);
      e.data  = e.resp ? 32'd0 : model_mem[a[AW+1:2]];
      exp_q.push_back(e);
    end
    // Load lands on the same edge that accepts the address phase.
    if (do_ld) begin
      ld_we = 1'b1; ld_addr = la; ld_wdata = ld_d;
      model_mem[la] = ld_d;
    end
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] tr);
    xfer(a, tr, 1'b1, 1'b0, 3'b010, 1'b0, '0, 32'd0);
  endtask

  task automatic idle(input int n);
    htrans = 2'b00;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_hold(input string name);
    check({name, "_hreadyout"}, {31'd0, hreadyout[cur]}, 32'd1);
    check({name, "_hresp"}, {31'd0, hresp[cur]}, 32'd0);
    check({name, "_hrdata"}, hrdata[cur], hold_exp[cur]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]   a;
    logic [1:0]    tr;
    logic [2:0]    sz;
    logic [AW-1:0] la;
    int            r;

    rst = 1'b1; cur = 0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hburst = '0; hprot = '0; hmastlock = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    for (int i = 0; i < N; i++) hold_exp[i] = 32'd0;
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) load_word(AW'(i), $urandom);

    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_dut%0d_hreadyout", i), {31'd0, hreadyout[i]}, 32'd1);
      check($sformatf("reset_dut%0d_hresp", i), {31'd0, hresp[i]}, 32'd0);
      check($sformatf("reset_dut%0d_hrdata", i), hrdata[i], 32'd0);
    end
    rst = 1'b0;
    idle(2);

    // Zero-wait pipelined fetch
    cur = 0;
    load_word(AW'(1), 32'h0040_0093);
    load_word(AW'(2), 32'h0050_0113);
    rd(32'h4, 2'b10);
    rd(32'h8, 2'b11);
    idle(3);
    check_hold("after_pipe");

    // BUSY and deselected NONSEQ leave the bus untouched
    rd(32'h20, 2'b01);
    xfer(32'h24, 2'b10, 1'b0, 1'b0, 3'b010, 1'b0, '0, 32'd0);
    idle(2);
    check_hold("busy_desel");

    // Error responses
    for (int k = 0; k < 2; k++) begin
      cur = k;
      xfer(32'h0,    2'b10, 1'b1, 1'b1, 3'b010, 1'b0, '0, 32'd0);
      xfer(32'h1000, 2'b10, 1'b1, 1'b0, 3'b010, 1'b0, '0, 32'd0);
      xfer(32'h2,    2'b10, 1'b1, 1'b0, 3'b010, 1'b0, '0, 32'd0);
      xfer(32'h0,    2'b10, 1'b1, 1'b0, 3'b001, 1'b0, '0, 32'd0);
      idle(6);
      check_hold("after_err");
    end

    // Wait states
    cur = 1;
    rd(32'h0, 2'b10);
    idle(6);

    // Load collision: read sees the old word, re-read sees the new one
    for (int k = 0; k < 2; k++) begin
      cur = k;
      load_word(AW'(5), 32'hAAAA_AAAA);
      xfer(32'h14, 2'b10, 1'b1, 1'b0, 3'b010, 1'b1, AW'(5), 32'h5555_5555);
      rd(32'h14, 2'b10);
      idle(6);
    end

    // Async reset in the middle of a wait-state transfer
    cur = 2;
    rd(32'h10, 2'b10);
    idle(5);
    rd(32'h18, 2'b10);
    htrans = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    check("midreset_hreadyout", {31'd0, hreadyout[2]}, 32'd1);
    check("midreset_hresp", {31'd0, hresp[2]}, 32'd0);
    check("midreset_hrdata", hrdata[2], 32'd0);
    exp_q.delete();
    hold_exp[2] = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    rd(32'h1C, 2'b10);
    idle(5);

    // Randomized traffic
    for (int seg = 0; seg < 6; seg++) begin
      cur = seg % N;
      repeat (40) begin
        r = $urandom_range(0, 99);
        if (r < 70)      a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        else if (r < 85) a = $urandom;
        else             a = {20'd0, 12'($urandom)};
        tr = ($urandom_range(0, 9) < 7) ? {1'b1, 1'($urandom)} : {1'b0, 1'($urandom)};
        sz = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b010;
        la = ($urandom_range(0, 1) == 0) ? a[AW+1:2] : AW'($urandom);
        xfer(a, tr, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, sz,
             $urandom_range(0, 3) == 0, la, $urandom);
      end
      idle(8);
      check_hold("rand_seg_end");
    end

    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ahb_code_mem_slave.md
Name: ahb_code_mem_slave

Overview:
AHB-Lite read-only slave for the core's instruction (code) bus. It answers the fetch stage's if_code_* master transfers. It holds a word-addressed instruction memory, inserts a configurable number of wait states, and returns the two-cycle ERROR response on illegal accesses. A side-band load port preloads the program before or during simulation and FPGA bring-up.

Parameters:
DEPTH, 1024, instruction memory size in 32-bit words (power of two, >= 2)
BASE_ADDR, 32'h00000000, byte address mapped to word 0 (DEPTH*4-aligned)
WAIT_STATES, 0, HREADYOUT-low cycles inserted before each OKAY data phase (0..15)

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST  in  1  asynchronous active-high reset
HSEL  in  1  slave select
HADDR  in  32  transfer byte address
HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  in  1  1 = write (always illegal here)
HSIZE  in  3  transfer size; only 3'b010 (word) legal
HBURST  in  3  accepted, ignored
HPROT  in  4  accepted, ignored
HMASTLOCK  in  1  accepted, ignored
HREADY  in  1  bus-level ready (address phase valid when high)
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 OKAY, 1 ERROR
ld_we  in  1  load-port word write enable
ld_addr  in  log2(DEPTH)  load-port word index
ld_wdata  in  32  load-port write data

Behaviour:
- Reset (async, RST=1): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, wait counter=0. Memory contents are not reset. RST asserted mid-transfer aborts it immediately; after release the block is in IDLE and ready.
- Address phase is accepted on a rising edge with HSEL=1, HREADY=1 and HTRANS[1]=1. Latch word index = (HADDR-BASE_ADDR)>>2 and an error flag.
- The error flag is set if any of these hold: HWRITE=1; HSIZE!=3'b010; HADDR[1:0]!=0; HADDR<BASE_ADDR; HADDR>=BASE_ADDR+DEPTH*4.
- HSEL=0, HREADY=0 or HTRANS IDLE/BUSY: no transfer. Response is OKAY with zero wait and no memory access.
- States:
  - IDLE: HREADYOUT=1, HRESP=0. Accepted transfer with error flag -> ERR1. Accepted legal transfer with WAIT_STATES=0 -> DATA. Accepted legal transfer with WAIT_STATES>0 -> WAIT, counter=WAIT_STATES-1.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements each cycle; at 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0, HRDATA=mem[index] (registered read, valid this cycle). A new address phase accepted this cycle follows the IDLE rules (back-to-back pipelining, no bubble). Otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, HRDATA=0 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1, HRDATA=0. An address phase in this cycle is accepted per the IDLE rules; otherwise -> IDLE.
- Outside DATA, HRDATA holds its last value, except in ERR1/ERR2 where it is 0.
- Latency: legal read data appears WAIT_STATES+1 cycles after the address-phase edge.
- Load port: ld_we=1 writes mem[ld_addr]=ld_wdata on the rising edge. It is independent of the bus state machine. If a load and a bus read hit the same word on the same edge, the read returns the old data (read-before-write).
- Width rules: index arithmetic is 32-bit unsigned, and the subtraction is performed only after the range check passes. Counter width is 4 bits.

Test Plan:
- Reset: RST=1 mid-WAIT (WAIT_STATES=2) -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; the first NONSEQ after release completes normally.
- Zero-wait pipelined fetch, WAIT_STATES=0, mem[1]=32'h00400093, mem[2]=32'h00500113: NONSEQ 0x4 then SEQ 0x8 on consecutive cycles -> HRDATA 00400093 then 00500113 on consecutive cycles, HREADYOUT=1 throughout.
- Wait states, WAIT_STATES=3: NONSEQ 0x0 -> HREADYOUT low for exactly 3 cycles, then high with HRDATA=mem[0].
- Error responses, DEPTH=1024:
  - HWRITE=1 at 0x0 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1), then OKAY.
  - HADDR=0x1000 -> same ERROR sequence.
  - HADDR=0x2 -> same ERROR sequence.
  - HSIZE=3'b001 -> same ERROR sequence.
- IDLE/BUSY/deselect: HTRANS=01, or HSEL=0 with HTRANS=10 -> HREADYOUT=1, HRESP=0, HRDATA unchanged.
- Load collision: mem[5]=32'hAAAAAAAA; ld_we writes 32'h55555555 to index 5 on the same edge as a read accept at 0x14 -> returns AAAAAAAA; a re-read returns 55555555.
